// File: rtl/id_ex_if.sv
// Decode-to-execute bus: decode fields, forwarding selects and values, hazard controls,
// and the registered A-stage fields returned to the forwarding unit.
interface id_ex_if #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 6,
  parameter int OPBITS    = 8
);
  logic                 d_valid;
  logic [OPBITS-1:0]    d_op;
  logic [REGNOBITS-1:0] d_sreg1;
  logic [REGNOBITS-1:0] d_sreg2;
  logic [REGNOBITS-1:0] d_dreg;
  logic                 d_is_lw;
  logic [DBITS-1:0]     d_imm;
  logic [DBITS-1:0]     d_pc;
  logic [DBITS-1:0]     rf_data1;
  logic [DBITS-1:0]     rf_data2;
  logic                 drive_A_src1;
  logic                 drive_A_src2;
  logic                 drive_M_src1;
  logic                 drive_M_src2;
  logic                 drive_W_src1;
  logic                 drive_W_src2;
  logic [DBITS-1:0]     fwd_A;
  logic [DBITS-1:0]     fwd_M;
  logic [DBITS-1:0]     fwd_W;
  logic                 stall;
  logic                 flush;
  logic                 d_hold;
  logic [OPBITS-1:0]    ex_op;
  logic [DBITS-1:0]     ex_src1;
  logic [DBITS-1:0]     ex_src2;
  logic [DBITS-1:0]     ex_imm;
  logic [DBITS-1:0]     ex_pc;
  logic [REGNOBITS-1:0] ex_dreg;
  logic                 ex_nop;
  logic                 ex_is_lw;
  logic [15:0]          stall_cnt;
  logic [15:0]          flush_cnt;

  // Upstream side: decode, register file and forwarding unit.
  modport master (
    output d_valid, d_op, d_sreg1, d_sreg2, d_dreg, d_is_lw, d_imm, d_pc,
    output rf_data1, rf_data2,
    output drive_A_src1, drive_A_src2, drive_M_src1, drive_M_src2, drive_W_src1, drive_W_src2,
    output fwd_A, fwd_M, fwd_W, stall, flush,
    input  d_hold, ex_op, ex_src1, ex_src2, ex_imm, ex_pc, ex_dreg, ex_nop, ex_is_lw,
    input  stall_cnt, flush_cnt
  );

  // The pipeline register itself.
  modport slave (
    input  d_valid, d_op, d_sreg1, d_sreg2, d_dreg, d_is_lw, d_imm, d_pc,
    input  rf_data1, rf_data2,
    input  drive_A_src1, drive_A_src2, drive_M_src1, drive_M_src2, drive_W_src1, drive_W_src2,
    input  fwd_A, fwd_M, fwd_W, stall, flush,
    output d_hold, ex_op, ex_src1, ex_src2, ex_imm, ex_pc, ex_dreg, ex_nop, ex_is_lw,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: resolves forwarded operands, latches decode fields into the
// A stage and inserts bubbles on reset, flush, load-use stall or an empty decode slot.
module id_ex_stage #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 6,
  parameter int OPBITS    = 8
) (
  input logic   clk,
  input logic   reset,
  id_ex_if.slave bus
);

  typedef enum logic {
    ST_BUBBLE = 1'b0,
    ST_VALID  = 1'b1
  } latch_state_t;

  latch_state_t     state;
  latch_state_t     state_next;
  logic [DBITS-1:0] src1;
  logic [DBITS-1:0] src2;
  logic             load;
  logic             stall_event;
  logic             flush_event;

  // A is newest, so it wins over M and W; register 0 always reads as zero.
  always_comb begin
    src1 = bus.rf_data1;
    if (bus.drive_A_src1)      src1 = bus.fwd_A;
    else if (bus.drive_M_src1) src1 = bus.fwd_M;
    else if (bus.drive_W_src1) src1 = bus.fwd_W;
    if (bus.d_sreg1 == '0)     src1 = '0;
  end

  always_comb begin
    src2 = bus.rf_data2;
    if (bus.drive_A_src2)      src2 = bus.fwd_A;
    else if (bus.drive_M_src2) src2 = bus.fwd_M;
    else if (bus.drive_W_src2) src2 = bus.fwd_W;
    if (bus.d_sreg2 == '0)     src2 = '0;
  end

  assign load        = bus.d_valid & ~bus.flush & ~bus.stall;
  assign stall_event = bus.stall & ~bus.flush & ~reset;
  assign flush_event = bus.flush & ~reset;
  assign bus.d_hold  = stall_event;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_BUBBLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = load ? ST_VALID : ST_BUBBLE;
  end

  always_comb begin
    bus.ex_nop = (state == ST_BUBBLE);
  end

  // Bubbles zero every field so the forwarding unit never matches a stale dreg.
  always_ff @(posedge clk) begin
    if (reset || !load) begin
      bus.ex_op    <= '0;
      bus.ex_src1  <= '0;
      bus.ex_src2  <= '0;
      bus.ex_imm   <= '0;
      bus.ex_pc    <= '0;
      bus.ex_dreg  <= '0;
      bus.ex_is_lw <= 1'b0;
    end else begin
      bus.ex_op    <= bus.d_op;
      bus.ex_src1  <= src1;
      bus.ex_src2  <= src2;
      bus.ex_imm   <= bus.d_imm;
      bus.ex_pc    <= bus.d_pc;
      bus.ex_dreg  <= bus.d_dreg;
      bus.ex_is_lw <= bus.d_is_lw;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.stall_cnt <= '0;
      bus.flush_cnt <= '0;
    end else begin
      if (stall_event && bus.stall_cnt != 16'hFFFF) bus.stall_cnt <= bus.stall_cnt + 16'd1;
      if (flush_event && bus.flush_cnt != 16'hFFFF) bus.flush_cnt <= bus.flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed steps plus random traffic against a
// transaction-level model of what the A stage should hold after each clock.
module tb_id_ex_stage;

  localparam int DBITS     = 32;
  localparam int REGNOBITS = 6;
  localparam int OPBITS    = 8;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  id_ex_if #(.DBITS(DBITS), .REGNOBITS(REGNOBITS), .OPBITS(OPBITS)) bus ();

  id_ex_stage #(.DBITS(DBITS), .REGNOBITS(REGNOBITS), .OPBITS(OPBITS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] dreg;
    logic        nop;
    logic        is_lw;
  } ex_slot_t;

  ex_slot_t exp_slot;
  int       exp_stall_cnt;
  int       exp_flush_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    total++;
    assert (obs === req)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Value an instruction would read for one source, as seen by the architecture.
  function automatic logic [31:0] operand(input int sreg, input logic [31:0] rf,
                                          input logic sel_a, input logic sel_m, input logic sel_w);
    if (sreg == 0) return 32'h0;
    if (sel_a)     return bus.fwd_A;
    if (sel_m)     return bus.fwd_M;
    if (sel_w)     return bus.fwd_W;
    return rf;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    ex_slot_t nxt;
    nxt = '{default: '0};
    nxt.nop = 1'b1;
    if (!(reset || bus.flush || bus.stall || !bus.d_valid)) begin
      nxt.op    = 32'(bus.d_op);
      nxt.src1  = operand(int'(bus.d_sreg1), bus.rf_data1, bus.drive_A_src1, bus.drive_M_src1, bus.drive_W_src1);
      nxt.src2  = operand(int'(bus.d_sreg2), bus.rf_data2, bus.drive_A_src2, bus.drive_M_src2, bus.drive_W_src2);
      nxt.imm   = bus.d_imm;
      nxt.pc    = bus.d_pc;
      nxt.dreg  = 32'(bus.d_dreg);
      nxt.nop   = 1'b0;
      nxt.is_lw = bus.d_is_lw;
    end
    exp_slot = nxt;
    if (reset) begin
      exp_stall_cnt = 0;
      exp_flush_cnt = 0;
    end else if (bus.flush) begin
      exp_flush_cnt = sat_inc(exp_flush_cnt);
    end else if (bus.stall) begin
      exp_stall_cnt = sat_inc(exp_stall_cnt);
    end
  endtask

  task automatic check_output(input string tag);
    chk({tag, ".ex_op"},    64'(bus.ex_op),    64'(exp_slot.op));
    chk({tag, ".ex_src1"},  64'(bus.ex_src1),  64'(exp_slot.src1));
    chk({tag, ".ex_src2"},  64'(bus.ex_src2),  64'(exp_slot.src2));
    chk({tag, ".ex_imm"},   64'(bus.ex_imm),   64'(exp_slot.imm));
    chk({tag, ".ex_pc"},    64'(bus.ex_pc),    64'(exp_slot.pc));
    chk({tag, ".ex_dreg"},  64'(bus.ex_dreg),  64'(exp_slot.dreg));
    chk({tag, ".ex_nop"},   64'(bus.ex_nop),   64'(exp_slot.nop));
    chk({tag, ".ex_is_lw"}, 64'(bus.ex_is_lw), 64'(exp_slot.is_lw));
    chk({tag, ".stall_cnt"}, 64'(bus.stall_cnt), 64'(exp_stall_cnt));
    chk({tag, ".flush_cnt"}, 64'(bus.flush_cnt), 64'(exp_flush_cnt));
  endtask

  // Inputs are already applied; check d_hold, clock once, then check the A stage.
  task automatic apply_stimulus(input string tag);
    #1;
    chk({tag, ".d_hold"}, 64'(bus.d_hold), 64'(bus.stall && !bus.flush && !reset));
    model_step();
    @(posedge clk);
    #1;
    check_output(tag);
  endtask

  task automatic set_idle();
    reset            = 1'b0;
    bus.d_valid      = 1'b0;
    bus.d_op         = '0;
    bus.d_sreg1      = '0;
    bus.d_sreg2      = '0;
    bus.d_dreg       = '0;
    bus.d_is_lw      = 1'b0;
    bus.d_imm        = '0;
    bus.d_pc         = '0;
    bus.rf_data1     = '0;
    bus.rf_data2     = '0;
    bus.drive_A_src1 = 1'b0;
    bus.drive_A_src2 = 1'b0;
    bus.drive_M_src1 = 1'b0;
    bus.drive_M_src2 = 1'b0;
    bus.drive_W_src1 = 1'b0;
    bus.drive_W_src2 = 1'b0;
    bus.fwd_A        = '0;
    bus.fwd_M        = '0;
    bus.fwd_W        = '0;
    bus.stall        = 1'b0;
    bus.flush        = 1'b0;
  endtask

  task automatic set_instr(input int sreg1, input int sreg2, input int dreg, input logic is_lw);
    bus.d_valid = 1'b1;
    bus.d_op    = 8'h5A;
    bus.d_sreg1 = 6'(sreg1);
    bus.d_sreg2 = 6'(sreg2);
    bus.d_dreg  = 6'(dreg);
    bus.d_is_lw = is_lw;
    bus.d_imm   = 32'hFFFF_FFF0;
    bus.d_pc    = 32'h0000_1000;
  endtask

  initial begin
    exp_slot      = '{default: '0};
    exp_slot.nop  = 1'b1;
    exp_stall_cnt = 0;
    exp_flush_cnt = 0;

    // Reset held two cycles with a valid instruction present.
    set_idle();
    set_instr(5, 6, 7, 1'b1);
    reset = 1'b1;
    apply_stimulus("reset0");
    apply_stimulus("reset1");
    reset = 1'b0;

    // Forwarding priority and pass-through.
    set_instr(5, 6, 9, 1'b0);
    bus.rf_data1 = 32'h11; bus.rf_data2 = 32'h22;
    bus.fwd_A = 32'hAA; bus.fwd_M = 32'hBB; bus.fwd_W = 32'hCC;
    bus.drive_M_src1 = 1'b1; bus.drive_W_src2 = 1'b1;
    apply_stimulus("fwd_m_w");
    chk("fwd_m_w.src1_lit", 64'(bus.ex_src1), 64'h BB);
    chk("fwd_m_w.src2_lit", 64'(bus.ex_src2), 64'h CC);
    bus.drive_A_src1 = 1'b1;
    apply_stimulus("fwd_a_prio");
    chk("fwd_a_prio.src1_lit", 64'(bus.ex_src1), 64'h AA);
    bus.drive_A_src1 = 1'b0; bus.drive_M_src1 = 1'b0; bus.drive_W_src2 = 1'b0;
    apply_stimulus("rf_pass");
    chk("rf_pass.src1_lit", 64'(bus.ex_src1), 64'h11);
    chk("rf_pass.src2_lit", 64'(bus.ex_src2), 64'h22);

    // Register 0 ignores forwarding.
    set_instr(0, 6, 4, 1'b0);
    bus.drive_A_src1 = 1'b1; bus.fwd_A = 32'hDEAD;
    apply_stimulus("r0_force");
    chk("r0_force.src1_lit", 64'(bus.ex_src1), 64'h0);
    bus.drive_A_src1 = 1'b0;

    // Load-use: lw, stall for one cycle, then the consumer picks the M path.
    set_instr(1, 2, 3, 1'b1);
    apply_stimulus("lw_issue");
    chk("lw_issue.is_lw_lit", 64'(bus.ex_is_lw), 64'h1);
    chk("lw_issue.dreg_lit", 64'(bus.ex_dreg), 64'h3);
    set_instr(3, 2, 8, 1'b0);
    bus.stall = 1'b1;
    apply_stimulus("lw_stall");
    chk("lw_stall.nop_lit", 64'(bus.ex_nop), 64'h1);
    chk("lw_stall.cnt_lit", 64'(bus.stall_cnt), 64'h1);
    bus.stall = 1'b0;
    bus.drive_M_src1 = 1'b1; bus.fwd_M = 32'h42;
    apply_stimulus("lw_resume");
    chk("lw_resume.src1_lit", 64'(bus.ex_src1), 64'h42);
    bus.drive_M_src1 = 1'b0;

    // Stall and flush together: flush wins.
    bus.stall = 1'b1; bus.flush = 1'b1;
    apply_stimulus("stall_flush");
    chk("stall_flush.flush_lit", 64'(bus.flush_cnt), 64'h1);
    chk("stall_flush.stall_lit", 64'(bus.stall_cnt), 64'h1);
    bus.stall = 1'b0; bus.flush = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset            = ($urandom_range(0, 39) == 0);
      bus.d_valid      = ($urandom_range(0, 3) != 0);
      bus.d_op         = 8'($urandom);
      bus.d_sreg1      = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom);
      bus.d_sreg2      = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom);
      bus.d_dreg       = 6'($urandom);
      bus.d_is_lw      = 1'($urandom);
      bus.d_imm        = $urandom;
      bus.d_pc         = $urandom;
      bus.rf_data1     = $urandom;
      bus.rf_data2     = $urandom;
      bus.drive_A_src1 = ($urandom_range(0, 3) == 0);
      bus.drive_A_src2 = ($urandom_range(0, 3) == 0);
      bus.drive_M_src1 = ($urandom_range(0, 2) == 0);
      bus.drive_M_src2 = ($urandom_range(0, 2) == 0);
      bus.drive_W_src1 = ($urandom_range(0, 1) == 0);
      bus.drive_W_src2 = ($urandom_range(0, 1) == 0);
      bus.fwd_A        = $urandom;
      bus.fwd_M        = $urandom;
      bus.fwd_W        = $urandom;
      bus.stall        = ($urandom_range(0, 4) == 0);
      bus.flush        = ($urandom_range(0, 7) == 0);
      apply_stimulus("random");
    end

    // Stall counter saturation, then reset clears it.
    set_idle();
    bus.stall = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      model_step();
      @(posedge clk);
    end
    #1;
    chk("sat.stall_cnt", 64'(bus.stall_cnt), 64'(exp_stall_cnt));
    chk("sat.stall_cnt_lit", 64'(bus.stall_cnt), 64'hFFFF);
    apply_stimulus("sat_hold");
    bus.stall = 1'b0;
    reset = 1'b1;
    apply_stimulus("sat_reset");
    chk("sat_reset.cnt_lit", 64'(bus.stall_cnt), 64'h0);
    reset = 1'b0;

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
